// File: rtl/smi_responder.sv
// Clause-22 MDIO responder: decodes MDC/MDIO read/write frames and serves a small PHY register file.
// Latency: mdc_rise 3 clk after the pad MDC edge; pad drive and register updates 1 clk after mdc_rise.
// Backpressure: none; the master paces every bit with MDC, each MDC phase must span at least 4 clk.
module smi_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_i,
    input  logic [1:0]  speed_i,
    output logic [15:0] ctrl_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_regad
);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RD_DATA, S_WR_DATA
    } state_t;

    localparam logic [15:0] CTRL_RST = 16'h1140;
    localparam logic [15:0] ANAR_RST = 16'h01E1;
    localparam logic [5:0]  PRE_MIN  = 6'(PREAMBLE_MIN);

    logic        mdc_s1, mdc_s2, mdc_d, mdc_rise;
    logic        mdio_s1, mdio_s2, mdio_bit;

    state_t      state_q, state_d;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic        op_hi, is_read, phy_match;
    logic [3:0]  phyad_sh;
    logic [4:0]  regad_sh;
    logic [15:0] rd_sh;
    logic [14:0] wr_sh;
    logic [15:0] ctrl_q, anar_q;
    logic        link_lat;

    logic [1:0]  op_full;
    logic [4:0]  regad_full;
    logic [15:0] wr_word;
    logic [15:0] rd_mux;
    logic        oe_d, o_d, shift_rd, commit, rd_done;

    // Synchronizers idle high so a high MDC at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_s1   <= 1'b1;
            mdc_s2   <= 1'b1;
            mdc_d    <= 1'b1;
            mdc_rise <= 1'b0;
            mdio_s1  <= 1'b1;
            mdio_s2  <= 1'b1;
        end else begin
            mdc_s1   <= mdc;
            mdc_s2   <= mdc_s1;
            mdc_d    <= mdc_s2;
            mdc_rise <= mdc_s2 & ~mdc_d;
            mdio_s1  <= mdio_i;
            mdio_s2  <= mdio_s1;
        end
    end

    assign mdio_bit   = mdio_s2;
    assign op_full    = {op_hi, mdio_bit};
    assign regad_full = {regad_sh[3:0], mdio_bit};
    assign wr_word    = {wr_sh, mdio_bit};

    always_comb begin
        rd_mux = 16'h0000;
        case (regad_full)
            5'd0:    rd_mux = {1'b0, ctrl_q[14:0]};
            5'd1:    rd_mux = 16'h7949 | {13'd0, link_lat, 2'b00};
            5'd2:    rd_mux = PHY_ID1;
            5'd3:    rd_mux = PHY_ID2;
            5'd4:    rd_mux = anar_q;
            5'd17:   rd_mux = {speed_i, 1'b1, 1'b0, link_i, link_i, 10'd0};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_PRE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mdc_rise) begin
            case (state_q)
                S_PRE:     if (!mdio_bit && pre_cnt >= PRE_MIN) state_d = S_ST;
                S_ST:      state_d = mdio_bit ? S_OP : S_PRE;
                S_OP:      if (bit_cnt[0]) state_d = (^op_full) ? S_PHYAD : S_PRE;
                S_PHYAD:   if (bit_cnt == 4'd4) state_d = S_REGAD;
                S_REGAD:   if (bit_cnt == 4'd4) state_d = S_TA;
                S_TA:      if (bit_cnt[0]) state_d = is_read ? S_RD_DATA : S_WR_DATA;
                S_RD_DATA,
                S_WR_DATA: if (bit_cnt == 4'd15) state_d = S_PRE;
                default:   state_d = S_PRE;
            endcase
        end
    end

    // Pad drive is decided on the bit being closed by this mdc_rise: the second TA bit is a
    // driven 0, then data MSB first, released after the master has sampled bit 0.
    always_comb begin
        oe_d     = mdio_oe;
        o_d      = mdio_o;
        shift_rd = 1'b0;
        commit   = 1'b0;
        rd_done  = 1'b0;
        if (mdc_rise) begin
            case (state_q)
                S_TA: begin
                    if (is_read && phy_match) begin
                        oe_d = 1'b1;
                        if (bit_cnt[0]) begin
                            o_d      = rd_sh[15];
                            shift_rd = 1'b1;
                        end else begin
                            o_d = 1'b0;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (phy_match) begin
                        if (bit_cnt == 4'd15) begin
                            oe_d    = 1'b0;
                            o_d     = 1'b1;
                            rd_done = 1'b1;
                        end else begin
                            o_d      = rd_sh[15];
                            shift_rd = 1'b1;
                        end
                    end
                end
                S_WR_DATA: commit = phy_match && (bit_cnt == 4'd15);
                default: begin
                    oe_d = 1'b0;
                    o_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= 6'd0;
            bit_cnt   <= 4'd0;
            op_hi     <= 1'b0;
            is_read   <= 1'b0;
            phy_match <= 1'b0;
            phyad_sh  <= 4'd0;
            regad_sh  <= 5'd0;
            rd_sh     <= 16'd0;
            wr_sh     <= 15'd0;
        end else if (mdc_rise) begin
            bit_cnt <= (state_d != state_q) ? 4'd0 : bit_cnt + 4'd1;
            // Any non-preamble bit, or any bit inside a frame, restarts the preamble count.
            if (state_q == S_PRE && mdio_bit)
                pre_cnt <= (pre_cnt == 6'd63) ? pre_cnt : pre_cnt + 6'd1;
            else
                pre_cnt <= 6'd0;
            case (state_q)
                S_OP: begin
                    op_hi   <= mdio_bit;
                    is_read <= (op_full == 2'b10);
                end
                S_PHYAD: begin
                    phyad_sh <= {phyad_sh[2:0], mdio_bit};
                    if (bit_cnt == 4'd4) phy_match <= ({phyad_sh, mdio_bit} == PHY_ADDR);
                end
                S_REGAD: begin
                    regad_sh <= regad_full;
                    if (bit_cnt == 4'd4) rd_sh <= rd_mux;
                end
                S_WR_DATA: wr_sh <= wr_word[14:0];
                default: ;
            endcase
            if (shift_rd) rd_sh <= {rd_sh[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b1;
            ctrl_q    <= CTRL_RST;
            anar_q    <= ANAR_RST;
            wr_strobe <= 1'b0;
            wr_regad  <= 5'd0;
            link_lat  <= 1'b0;
        end else begin
            mdio_oe   <= oe_d;
            mdio_o    <= o_d;
            wr_strobe <= commit;
            // Latching-low link: any drop clears it, a completed reg-1 read re-arms it.
            link_lat  <= link_i & (link_lat | (rd_done && regad_sh == 5'd1));
            if (commit) begin
                wr_regad <= regad_sh;
                case (regad_sh)
                    5'd0:    ctrl_q <= wr_word[15] ? CTRL_RST : wr_word;
                    5'd4:    anar_q <= wr_word;
                    default: ;
                endcase
            end
        end
    end

    assign ctrl_reg = ctrl_q;

endmodule

// File: tb/tb_smi_responder.sv
// Bench for smi_responder: directed and randomized Clause-22 frames against a register-level model.
module tb_smi_responder;

    localparam logic [4:0] PHY_ADDR = 5'd0;
    localparam int         PRE_MIN  = 32;
    localparam int         HALF     = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b1;
    logic        mdio_i = 1'b1;
    logic        link_i = 1'b1;
    logic [1:0]  speed_i = 2'b10;
    logic        mdio_o, mdio_oe, wr_strobe;
    logic [15:0] ctrl_reg;
    logic [4:0]  wr_regad;

    int          n_checks = 0;
    int          n_fail = 0;
    int          oe_cnt = 0;
    int          strobe_cnt = 0;
    logic [4:0]  last_regad = 5'd0;
    logic        s_oe, s_o;

    logic [15:0] m_ctrl = 16'h1140;
    logic [15:0] m_anar = 16'h01E1;
    logic        m_lat = 1'b0;

    smi_responder #(
        .PHY_ADDR(PHY_ADDR), .PHY_ID1(16'h0141), .PHY_ID2(16'h0CC2), .PREAMBLE_MIN(PRE_MIN)
    ) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .link_i(link_i), .speed_i(speed_i), .ctrl_reg(ctrl_reg), .wr_strobe(wr_strobe),
        .wr_regad(wr_regad)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mdio_oe) oe_cnt++;
        if (wr_strobe) begin
            strobe_cnt++;
            last_regad = wr_regad;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] ra);
        case (ra)
            5'd0:    return m_ctrl & 16'h7FFF;
            5'd1:    return m_lat ? 16'h794D : 16'h7949;
            5'd2:    return 16'h0141;
            5'd3:    return 16'h0CC2;
            5'd4:    return m_anar;
            5'd17:   return 16'(32'(speed_i) * 16384 + 32'h2000 + (link_i ? 32'h0C00 : 32'h0));
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] ra, input logic [15:0] wd);
        if (ra == 5'd0) m_ctrl = wd[15] ? 16'h1140 : wd;
        if (ra == 5'd4) m_anar = wd;
    endtask

    // One MDC bit: data set while MDC is low, pad sampled just before the rising edge.
    task automatic send_bit(input logic b);
        mdc    = 1'b0;
        mdio_i = b;
        repeat (HALF) @(negedge clk);
        s_oe = mdio_oe;
        s_o  = mdio_o;
        mdc  = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd, input int stop_bits,
                             output logic [15:0] rd, output int drv, output logic ta0_oe,
                             output logic [1:0] ta1);
        logic [15:0] hdr;
        logic        rd_op;
        int          sent;
        rd_op  = (op == 2'b10);
        hdr    = {2'b01, op, pa, ra, rd_op ? 2'b11 : 2'b10};
        rd     = 16'h0;
        drv    = 0;
        ta0_oe = 1'b0;
        ta1    = 2'b00;
        sent   = 0;
        send_bit(1'b0);
        for (int i = 0; i < npre; i++) send_bit(1'b1);
        for (int i = 15; i >= 0; i--) begin
            send_bit(hdr[i]);
            if (i == 1) ta0_oe = s_oe;
            if (i == 0) ta1 = {s_oe, s_o};
            sent++;
            if (sent == stop_bits) return;
        end
        for (int i = 15; i >= 0; i--) begin
            send_bit(rd_op ? 1'b1 : wd[i]);
            rd[i] = s_o;
            if (s_oe) drv++;
            sent++;
            if (sent == stop_bits) return;
        end
    endtask

    task automatic do_read(input string tag, input int npre, input logic [4:0] pa,
                           input logic [4:0] ra);
        logic [15:0] rd, exp;
        int          drv, oe0, st0;
        logic        ta0, hit;
        logic [1:0]  ta1;
        hit = (pa == PHY_ADDR) && (npre >= PRE_MIN);
        exp = model_read(ra);
        oe0 = oe_cnt;
        st0 = strobe_cnt;
        run_frame(npre, 2'b10, pa, ra, 16'h0, -1, rd, drv, ta0, ta1);
        if (hit) begin
            check({tag, " ta_z"}, 32'(ta0), 32'd0);
            check({tag, " ta_0"}, 32'(ta1), 32'h2);
            check({tag, " data"}, 32'(rd), 32'(exp));
            check({tag, " drive"}, drv, 16);
            check({tag, " release"}, 32'(mdio_oe), 32'd0);
            if (ra == 5'd1) m_lat = link_i;
        end else begin
            check({tag, " no_drive"}, oe_cnt - oe0, 0);
        end
        check({tag, " no_strobe"}, strobe_cnt - st0, 0);
    endtask

    task automatic do_write(input string tag, input int npre, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        logic [15:0] rd;
        int          drv, oe0, st0;
        logic        ta0, ok;
        logic [1:0]  ta1;
        ok  = (pa == PHY_ADDR) && (npre >= PRE_MIN) && (op == 2'b01);
        oe0 = oe_cnt;
        st0 = strobe_cnt;
        run_frame(npre, op, pa, ra, wd, -1, rd, drv, ta0, ta1);
        if (ok) begin
            check({tag, " strobe"}, strobe_cnt - st0, 1);
            check({tag, " wr_regad"}, 32'(last_regad), 32'(ra));
            model_write(ra, wd);
        end else begin
            check({tag, " no_strobe"}, strobe_cnt - st0, 0);
        end
        check({tag, " no_drive"}, oe_cnt - oe0, 0);
        check({tag, " ctrl_reg"}, 32'(ctrl_reg), 32'(m_ctrl));
    endtask

    initial begin
        logic [15:0] rd;
        int          drv;
        logic        ta0;
        logic [1:0]  ta1;

        repeat (3) @(negedge clk);
        check("rst mdio_oe", 32'(mdio_oe), 32'd0);
        check("rst mdio_o", 32'(mdio_o), 32'd1);
        check("rst ctrl_reg", 32'(ctrl_reg), 32'h1140);
        check("rst wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst wr_regad", 32'(wr_regad), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_read("read_id1", 32, PHY_ADDR, 5'd2);
        do_read("read_id2", 32, PHY_ADDR, 5'd3);
        do_write("wr_anar", 32, 2'b01, PHY_ADDR, 5'd4, 16'hABCD);
        do_read("rd_anar", 32, PHY_ADDR, 5'd4);
        do_write("soft_rst", 32, 2'b01, PHY_ADDR, 5'd0, 16'h8000);
        check("soft_rst value", 32'(ctrl_reg), 32'h1140);
        do_read("rd_ctrl", 32, PHY_ADDR, 5'd0);

        link_i = 1'b0;
        m_lat  = 1'b0;
        repeat (4) @(negedge clk);
        link_i = 1'b1;
        repeat (4) @(negedge clk);
        do_read("link_lat0", 32, PHY_ADDR, 5'd1);
        do_read("link_lat1", 32, PHY_ADDR, 5'd1);

        speed_i = 2'b10;
        do_read("reg17", 32, PHY_ADDR, 5'd17);
        check("reg17 model", 32'(model_read(5'd17)), 32'hAC00);

        do_read("phyad_miss", 32, 5'd7, 5'd2);
        do_write("wr_miss", 32, 2'b01, 5'd9, 5'd4, 16'h1234);
        do_write("op11", 32, 2'b11, PHY_ADDR, 5'd4, 16'h5555);
        do_write("short_pre_wr", 31, 2'b01, PHY_ADDR, 5'd4, 16'h7777);
        do_read("short_pre_rd", 31, PHY_ADDR, 5'd2);
        do_write("wr_ro", 33, 2'b01, PHY_ADDR, 5'd17, 16'hFFFF);
        do_write("wr_ctrl", 32, 2'b01, PHY_ADDR, 5'd0, 16'h2100);

        // Abort a matched read mid-data with reset.
        run_frame(32, 2'b10, PHY_ADDR, 5'd3, 16'h0, 20, rd, drv, ta0, ta1);
        check("abort driving", 32'(mdio_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("abort mdio_oe", 32'(mdio_oe), 32'd0);
        check("abort mdio_o", 32'(mdio_o), 32'd1);
        check("abort ctrl_reg", 32'(ctrl_reg), 32'h1140);
        m_ctrl = 16'h1140;
        m_anar = 16'h01E1;
        m_lat  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_read("post_rst id", 32, PHY_ADDR, 5'd2);
        do_read("post_rst anar", 32, PHY_ADDR, 5'd4);
        do_read("post_rst reg1", 32, PHY_ADDR, 5'd1);

        for (int k = 0; k < 24; k++) begin
            logic [4:0] ra, pa;
            int         kind, npre;
            if ($urandom_range(0, 3) == 0) begin
                link_i = 1'($urandom_range(0, 1));
                if (!link_i) m_lat = 1'b0;
            end
            speed_i = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 6))
                0:       ra = 5'd0;
                1:       ra = 5'd1;
                2:       ra = 5'd2;
                3:       ra = 5'd3;
                4:       ra = 5'd4;
                5:       ra = 5'd17;
                default: ra = 5'($urandom_range(5, 16));
            endcase
            pa   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : PHY_ADDR;
            npre = $urandom_range(32, 36);
            kind = $urandom_range(0, 9);
            if (kind < 5)
                do_read($sformatf("rnd%0d rd r%0d", k, ra), npre, pa, ra);
            else if (kind < 9)
                do_write($sformatf("rnd%0d wr r%0d", k, ra), npre, 2'b01, pa, ra, 16'($urandom));
            else
                do_write($sformatf("rnd%0d badop", k), npre,
                         ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, pa, ra, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smi_responder.md
# smi_responder

Clause-22 MDIO management responder: the PHY-side counterpart of the switch's SMI master. It decodes read and write frames on MDC/MDIO, serves a small PHY register model, and drives read data back on a split tristate MDIO. The block serves two purposes: it lets the MAC/SMI subsystem be simulated and looped back without a physical PHY, and it lets an FPGA-emulated port present a standard management interface. It reports link and speed through the same registers the SMI master polls: reg 1 bit 2 and reg 17 bits 15:14/10.

## Interface
- PHY_ADDR, 5'd0, PHY address this responder answers to.
- PHY_ID1, 16'h0141, value returned by reg 2.
- PHY_ID2, 16'h0CC2, value returned by reg 3.
- PREAMBLE_MIN, 32, consecutive 1 bits required before a start-of-frame is accepted (1..63).
- clk  in  1  system clock; all logic is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mdc  in  1  management clock from the master, asynchronous to clk.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO output enable; 1 = responder drives the pad.
- link_i  in  1  emulated link state.
- speed_i  in  2  emulated speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- ctrl_reg  out  16  current reg 0 value.
- wr_strobe  out  1  one-cycle pulse when a write to this PHY_ADDR commits.
- wr_regad  out  5  register address of the last committed write.

## Operation
- mdc and mdio_i each pass through a 2-flop synchronizer. A rising-edge pulse (mdc_rise) is generated from the synchronized mdc.
- All frame sampling and state advance happen only on mdc_rise. Sampled bit = synchronized mdio_i.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA.
  - PRE: pre_cnt (6 bits) counts consecutive 1s and saturates at 63. A 0 is treated as the first ST bit when pre_cnt ≥ PREAMBLE_MIN, and the FSM goes to ST. Otherwise a 0 clears pre_cnt.
  - ST: the second bit must be 1. Otherwise the FSM returns to PRE with pre_cnt = 0.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 returns to PRE with pre_cnt = 0.
  - PHYAD: 5 bits, MSB first, then REGAD: 5 bits, then TA: 2 bits.
  - RD_DATA and WR_DATA: 16 bits each. Then the FSM returns to PRE with pre_cnt = 0.
- Address match = PHYAD == PHY_ADDR. On a mismatch the FSM still walks the full frame, never drives the pad, and never writes.
- Read drive sequence (matched read only):
  - At the first TA bit: mdio_oe stays 0.
  - At the mdc_rise ending the first TA bit: mdio_oe = 1, mdio_o = 0.
  - At each following mdc_rise: drive the next data bit, MSB first. The read word is latched at the end of REGAD.
  - At the mdc_rise after data bit 0: mdio_oe = 0.
- In a write, TA bits are ignored. The data shift register commits on the mdc_rise that samples bit 0.
- Register model (unlisted addresses read 0 and ignore writes):
  - reg 0, reset value 0x1140, R/W. Writing bit 15 = 1 reloads 0x1140 (self-clearing soft reset). Bit 15 always reads 0.
  - reg 1, read-only: 0x7949 with bit 2 = link_lat.
    - link_lat clears whenever link_i = 0 (latching-low).
    - When a matched reg-1 read frame completes, link_lat is set to the current link_i.
    - Reset value of link_lat: 0.
  - reg 2 = PHY_ID1, reg 3 = PHY_ID2.
  - reg 4, reset value 0x01E1, R/W.
  - reg 17, read-only: {speed_i, 1'b1, 1'b0, link_i, link_i, 10'b0}, i.e. bits 15:14 = speed, 13 = duplex, 11 = resolved, 10 = link.
- wr_strobe pulses for every committed matched write, including writes to read-only or unlisted addresses. wr_regad is updated with the pulse.

## Timing
- mdc_rise asserts 3 clk cycles after a pad rising edge of mdc (2 synchronizer flops + edge register).
- mdio_o and mdio_oe are registered and change 1 cycle after mdc_rise. Pad output therefore trails the MDC rising edge by 4 clk cycles; this is within the 0–300 ns PHY output window when clk = 200 MHz.
- Requirement on the master: MDC high and low phases are each ≥ 4 clk cycles. The SMI master at 200 MHz / 500 kHz satisfies this with 200 cycles per phase.
- wr_strobe, ctrl_reg and register updates take effect 1 cycle after the committing mdc_rise.
- Reset (asynchronous, any time, including mid-frame):
  - Output values: mdio_oe = 0, mdio_o = 1, ctrl_reg = 0x1140, wr_strobe = 0, wr_regad = 0.
  - Internal state: FSM = PRE, pre_cnt = 0, reg 4 = 0x01E1, link_lat = 0.
- A frame aborted mid-stream by the master does not resynchronize until a new preamble is seen. The FSM completes its bit count, then requires PREAMBLE_MIN ones.
- Back-to-back frames need no idle between them beyond the preamble.

## Test plan
- Read ID: 32×1 preamble, read PHYAD = PHY_ADDR, REGAD = 2 -> TA driven Z then 0; 16 bits return 0x0141; mdio_oe = 0 after bit 0.
- Write/readback: write reg 4 = 0xABCD -> one wr_strobe with wr_regad = 4; a following read returns 0xABCD.
- Soft reset: write reg 0 = 0x8000 -> ctrl_reg = 0x1140; reading reg 0 returns 0x1140.
- Latching link: link_i 1→0→1, then read reg 1 -> bit 2 = 0; read again -> bit 2 = 1.
- Reg 17 with link_i = 1, speed_i = 10 -> read returns 0xAC00.
- Negative cases, each -> mdio_oe stays 0 and no wr_strobe:
  - PHYAD mismatch;
  - OP = 11;
  - only 31 preamble ones;
  - rst asserted mid-read data -> mdio_oe = 0 immediately, and the next valid frame is served.
